// File: rtl/vga_if.sv
// vga_if: one pixel of a VGA stream (raster position, syncs, blanking, 4:4:4 colour).
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect.sv
// draw_rect: overlays a fixed-size rectangle on a vga_if stream with 2-clk latency on every field.
// Define DRAW_RECT_BORDER_EN to paint a BORDER_W-thick BORDER_RGB outline inside the rectangle.
module draw_rect #(
  parameter int unsigned RECT_W     = 128,
  parameter int unsigned RECT_H     = 96,
  parameter logic [11:0] RECT_RGB   = 12'hF80,
  parameter int unsigned BORDER_W   = 4,
  parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  vga_if.in           in,
  vga_if.out          out
);
  localparam logic [12:0] W13 = 13'(RECT_W);
  localparam logic [12:0] H13 = 13'(RECT_H);

  logic [11:0] x_sh_q, y_sh_q;
  logic        vblnk_d_q;

  logic [10:0] hcount_s1_q, vcount_s1_q;
  logic        hsync_s1_q, vsync_s1_q, hblnk_s1_q, vblnk_s1_q;
  logic [11:0] rgb_s1_q;
  logic        inside_s1_q;

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0] rgb_q;

  logic [12:0] h13, v13, x_lo, x_hi, y_lo, y_hi;
  logic        inside_d;
  logic [11:0] rgb_d;

  // 13-bit bounds so a rectangle hanging off the right/bottom edge never wraps to 0.
  always_comb begin
    h13      = {2'b00, in.hcount};
    v13      = {2'b00, in.vcount};
    x_lo     = {1'b0, x_sh_q};
    y_lo     = {1'b0, y_sh_q};
    x_hi     = x_lo + W13;
    y_hi     = y_lo + H13;
    inside_d = (h13 >= x_lo) && (h13 < x_hi) && (v13 >= y_lo) && (v13 < y_hi);
  end

`ifdef DRAW_RECT_BORDER_EN
  localparam bit BORDER_ALL = (2 * BORDER_W >= RECT_W) || (2 * BORDER_W >= RECT_H);
  localparam logic [12:0] BW13    = 13'(BORDER_W);
  localparam logic [12:0] INNER_W = BORDER_ALL ? 13'd0 : 13'(RECT_W - BORDER_W);
  localparam logic [12:0] INNER_H = BORDER_ALL ? 13'd0 : 13'(RECT_H - BORDER_W);

  logic interior_d;
  logic border_s1_q;

  always_comb begin
    interior_d = !BORDER_ALL
              && (h13 >= x_lo + BW13) && (h13 < x_lo + INNER_W)
              && (v13 >= y_lo + BW13) && (v13 < y_lo + INNER_H);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      border_s1_q <= 1'b0;
    end else begin
      border_s1_q <= inside_d && !interior_d;
    end
  end
`endif

  always_comb begin
    rgb_d = rgb_s1_q;
    if (hblnk_s1_q || vblnk_s1_q) begin
      rgb_d = 12'h000;
    end else if (inside_s1_q) begin
`ifdef DRAW_RECT_BORDER_EN
      rgb_d = border_s1_q ? BORDER_RGB : RECT_RGB;
`else
      rgb_d = RECT_RGB;
`endif
    end
  end

  // Shadow position is only reloaded on the first cycle of vertical blanking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_sh_q    <= '0;
      y_sh_q    <= '0;
      vblnk_d_q <= 1'b0;
    end else begin
      vblnk_d_q <= in.vblnk;
      if (in.vblnk && !vblnk_d_q) begin
        x_sh_q <= xpos;
        y_sh_q <= ypos;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_s1_q <= '0;
      vcount_s1_q <= '0;
      hsync_s1_q  <= 1'b0;
      vsync_s1_q  <= 1'b0;
      hblnk_s1_q  <= 1'b0;
      vblnk_s1_q  <= 1'b0;
      rgb_s1_q    <= '0;
      inside_s1_q <= 1'b0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      rgb_q       <= '0;
    end else begin
      hcount_s1_q <= in.hcount;
      vcount_s1_q <= in.vcount;
      hsync_s1_q  <= in.hsync;
      vsync_s1_q  <= in.vsync;
      hblnk_s1_q  <= in.hblnk;
      vblnk_s1_q  <= in.vblnk;
      rgb_s1_q    <= in.rgb;
      inside_s1_q <= inside_d;
      hcount_q    <= hcount_s1_q;
      vcount_q    <= vcount_s1_q;
      hsync_q     <= hsync_s1_q;
      vsync_q     <= vsync_s1_q;
      hblnk_q     <= hblnk_s1_q;
      vblnk_q     <= vblnk_s1_q;
      rgb_q       <= rgb_d;
    end
  end

  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.vsync  = vsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vblnk  = vblnk_q;
  assign out.rgb    = rgb_q;
endmodule

// File: tb/tb_draw_rect.sv
// tb_draw_rect: directed and random pixel stimulus checked against a pixel-level reference model.
module tb_draw_rect;
  localparam int W  = 128;
  localparam int H  = 96;
  localparam int BW = 4;
  localparam logic [11:0] RECT_RGB   = 12'hF80;
  localparam logic [11:0] BORDER_RGB = 12'hFFF;
  localparam logic [11:0] BG         = 12'h00F;
`ifdef DRAW_RECT_BORDER_EN
  localparam logic [11:0] EDGE_RGB = BORDER_RGB;
`else
  localparam logic [11:0] EDGE_RGB = RECT_RGB;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;

  vga_if vin ();
  vga_if vout ();

  draw_rect dut (
    .clk  (clk),
    .rst  (rst),
    .xpos (xpos),
    .ypos (ypos),
    .in   (vin),
    .out  (vout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        spot;
    logic [11:0] spot_rgb;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   sh_x = 0;
  int   sh_y = 0;
  bit   prev_vb = 1'b0;
  bit   rst_want = 1'b0;

  // Reference pixel colour straight from the overlay rules, using plain integer geometry.
  function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb, logic [11:0] rgb,
                                            int x, int y);
    int d;
    if (hb || vb) return 12'h000;
    if (h >= x && h < x + W && v >= y && v < y + H) begin
      d = h - x;
      if (x + W - 1 - h < d) d = x + W - 1 - h;
      if (v - y < d) d = v - y;
      if (y + H - 1 - v < d) d = y + H - 1 - v;
`ifdef DRAW_RECT_BORDER_EN
      if (d < BW) return BORDER_RGB;
`endif
      return RECT_RGB;
    end
    return rgb;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: check the output due now, then drive the next input and queue its expectation.
  task automatic step(input int h, input int v, input bit hb, input bit vb,
                      input logic [11:0] rgb, input bit spot, input logic [11:0] spot_rgb);
    exp_t e;
    exp_t n;
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("timing", {6'd0, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
          {6'd0, e.h, e.v, e.hs, e.vs, e.hb, e.vb});
    check("rgb", {20'd0, vout.rgb}, {20'd0, e.rgb});
    if (e.spot) check("spot_rgb", {20'd0, vout.rgb}, {20'd0, e.spot_rgb});
    rst = rst_want;
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = 1'($urandom);
    vin.vsync  = 1'($urandom);
    vin.rgb    = rgb;
    n = '0;
    if (rst) begin
      n.h   = vin.hcount;
      n.v   = vin.vcount;
      n.hs  = vin.hsync;
      n.vs  = vin.vsync;
      n.hb  = hb;
      n.vb  = vb;
      n.rgb = model_rgb(h, v, hb, vb, rgb, sh_x, sh_y);
      n.spot = spot;
      n.spot_rgb = spot_rgb;
      if (vb && !prev_vb) begin
        sh_x = int'(xpos);
        sh_y = int'(ypos);
      end
      prev_vb = vb;
    end
    q.push_back(n);
  endtask

  task automatic px(input int h, input int v, input logic [11:0] rgb,
                    input bit spot, input logic [11:0] spot_rgb);
    step(h, v, h >= 1024, v >= 768, rgb, spot, spot_rgb);
  endtask

  task automatic capture(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
    px(0, 767, BG, 1'b0, 12'h000);
    px(0, 768, BG, 1'b0, 12'h000);
    px(1, 768, BG, 1'b0, 12'h000);
    px(0, 0, BG, 1'b0, 12'h000);
  endtask

  task automatic assert_reset();
    rst_want = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rst", {6'd0, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
          32'd0);
    check("async_rst_rgb", {20'd0, vout.rgb}, 32'd0);
    q.delete();
    q.push_back('0);
    q.push_back('0);
    sh_x = 0;
    sh_y = 0;
    prev_vb = 1'b0;
  endtask

  initial begin
    int h;
    int v;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
    q.push_back('0);
    q.push_back('0);

    // Reset held 3 clk with live input, then release; first frame uses shadow (0,0)
    for (int i = 0; i < 3; i++) px(10 + i, 20, BG, 1'b0, 12'h000);
    rst_want = 1'b1;
    px(5, 5, BG, 1'b1, RECT_RGB);
    px(0, 0, BG, 1'b1, EDGE_RGB);
    px(128, 5, BG, 1'b1, BG);

    // Alignment at (100,50)
    capture(100, 50);
    px(99, 50, BG, 1'b1, BG);
    px(100, 50, BG, 1'b1, EDGE_RGB);
    px(227, 145, BG, 1'b1, EDGE_RGB);
    px(228, 50, BG, 1'b1, BG);
    px(100, 146, BG, 1'b1, BG);
    px(103, 60, BG, 1'b1, EDGE_RGB);
    px(104, 54, BG, 1'b1, RECT_RGB);
    px(104, 53, BG, 1'b1, EDGE_RGB);
    px(150, 100, BG, 1'b1, RECT_RGB);
    step(150, 100, 1'b1, 1'b0, BG, 1'b1, 12'h000);

    // Deferred position update
    capture(100, 350);
    xpos = 12'd300;
    px(150, 400, BG, 1'b1, RECT_RGB);
    px(150, 420, BG, 1'b1, RECT_RGB);
    px(320, 420, BG, 1'b1, BG);
    capture(300, 350);
    px(150, 420, BG, 1'b1, BG);
    px(320, 420, BG, 1'b1, RECT_RGB);

    // Clipping at the bottom-right corner, then off-screen
    capture(1000, 700);
    px(1000, 700, BG, 1'b1, EDGE_RGB);
    px(1020, 710, BG, 1'b1, RECT_RGB);
    px(1023, 767, BG, 1'b1, RECT_RGB);
    px(10, 700, BG, 1'b1, BG);
    px(1050, 700, BG, 1'b1, 12'h000);
    capture(4095, 0);
    for (int i = 0; i < 40; i++) begin
      logic [11:0] c;
      c = 12'($urandom);
      px($urandom_range(0, 1023), $urandom_range(0, 767), c, 1'b1, c);
    end

    // Mid-frame reset at vcount 300
    capture(100, 250);
    px(120, 300, BG, 1'b1, RECT_RGB);
    assert_reset();
    px(121, 300, BG, 1'b0, 12'h000);
    px(122, 300, BG, 1'b0, 12'h000);
    rst_want = 1'b1;
    px(123, 300, BG, 1'b0, 12'h000);
    px(5, 5, BG, 1'b0, 12'h000);
    px(124, 300, BG, 1'b1, BG);
    px(5, 5, BG, 1'b1, RECT_RGB);
    px(2, 2, BG, 1'b1, EDGE_RGB);
    capture(100, 50);
    px(100, 50, BG, 1'b1, EDGE_RGB);

    // Random pixels, mostly around the current rectangle, with occasional repositioning
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        xpos = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'($urandom_range(0, 1100));
        ypos = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'($urandom_range(0, 800));
      end
      if ($urandom_range(0, 1) == 1) begin
        h = sh_x + $urandom_range(0, W + 8) - 4;
        v = sh_y + $urandom_range(0, H + 8) - 4;
      end else begin
        h = $urandom_range(0, 1343);
        v = $urandom_range(0, 805);
      end
      if (h < 0) h = 0;
      if (h > 1343) h = 1343;
      if (v < 0) v = 0;
      if (v > 805) v = 805;
      step(h, v, (h >= 1024) || ($urandom_range(0, 15) == 0), v >= 768, 12'($urandom),
           1'b0, 12'h000);
    end

    px(0, 0, BG, 1'b0, 12'h000);
    px(0, 0, BG, 1'b0, 12'h000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
